// File: rtl/fp_normalize_round.sv
// Back-end of the single-precision adder: normalizes the raw significand sum one bit
// per cycle, rounds to nearest-even and packs an IEEE-754 result with saturation/flush.
module fp_normalize_round (
    input  logic        clk,
    input  logic        res,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [26:0] sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    localparam int unsigned EW = 9;
    localparam int unsigned MW = 27;
    localparam int unsigned RW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            s, s_nxt;
    logic [EW-1:0]   e, e_nxt;
    logic [MW-1:0]   m, m_nxt;
    logic            renorm, renorm_nxt;
    logic [RW-1:0]   result_nxt;
    logic            overflow_nxt, underflow_nxt;

    logic [EW-1:0]   e_inc, e_dec;
    logic [MW-1:0]   m_rsh, m_lsh, m_rnd;
    logic            rnd_inc;
    logic            in_special, in_zero;

    // Datapath candidates shared by the next-state and output logic
    assign e_inc      = e + EW'(1);
    assign e_dec      = e - EW'(1);
    assign m_rsh      = {1'b0, m[26:2], m[1] | m[0]};
    assign m_lsh      = {m[25:0], 1'b0};
    assign rnd_inc    = m[1] & (m[0] | m[2]);
    assign m_rnd      = m + (rnd_inc ? MW'(4) : MW'(0));
    assign in_special = (exp == 8'hFF);
    assign in_zero    = (sum == MW'(0)) || (exp == 8'h00);

    // State register plus all registered datapath and outputs
    always_ff @(posedge clk) begin
        if (!res) begin
            state     <= IDLE;
            s         <= 1'b0;
            e         <= '0;
            m         <= '0;
            renorm    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            s         <= s_nxt;
            e         <= e_nxt;
            m         <= m_nxt;
            renorm    <= renorm_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            result    <= result_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_special || in_zero) state_nxt = DONE;
                    else                       state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (m[26]) begin
                    // After a rounding carry the single right shift is known to normalize
                    if (e_inc == EW'(255)) state_nxt = DONE;
                    else if (renorm)       state_nxt = ROUND;
                    else                   state_nxt = SHIFT;
                end else if (!m[25]) begin
                    if (e_dec == EW'(0)) state_nxt = DONE;
                    else                 state_nxt = SHIFT;
                end else begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (m_rnd[26]) state_nxt = SHIFT;
                else           state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        s_nxt         = s;
        e_nxt         = e;
        m_nxt         = m;
        renorm_nxt    = renorm;
        result_nxt    = result;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    s_nxt         = sign;
                    e_nxt         = {1'b0, exp};
                    m_nxt         = sum;
                    renorm_nxt    = 1'b0;
                    overflow_nxt  = 1'b0;
                    underflow_nxt = 1'b0;
                    if (in_special) begin
                        result_nxt   = {sign, 8'hFF, 23'h0};
                        overflow_nxt = 1'b1;
                    end else if (in_zero) begin
                        result_nxt    = {sign, 31'h0};
                        underflow_nxt = (sum != MW'(0));
                    end
                end
            end
            SHIFT: begin
                if (m[26]) begin
                    m_nxt      = m_rsh;
                    e_nxt      = e_inc;
                    renorm_nxt = 1'b0;
                    if (e_inc == EW'(255)) begin
                        result_nxt   = {s, 8'hFF, 23'h0};
                        overflow_nxt = 1'b1;
                    end
                end else if (!m[25]) begin
                    m_nxt = m_lsh;
                    e_nxt = e_dec;
                    if (e_dec == EW'(0)) begin
                        result_nxt    = {s, 31'h0};
                        underflow_nxt = 1'b1;
                    end
                end
            end
            ROUND: begin
                m_nxt      = m_rnd;
                renorm_nxt = m_rnd[26];
                if (!m_rnd[26]) result_nxt = {s, e[7:0], m_rnd[24:2]};
            end
            default: ;
        endcase
    end

endmodule
